// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: o_diff = x - y - bin, o_bout set on borrow.
module full_sub_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~i_x & i_bin) | (i_y & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin_init), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin_init,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;

    logic w_cell_diff;
    logic w_cell_bout;

    full_sub_cell u_cell (
        .i_x    (r_a_sr[0]),
        .i_y    (r_b_sr[0]),
        .i_bin  (r_brw),
        .o_diff (w_cell_diff),
        .o_bout (w_cell_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_brw   <= bin_init;
                        r_cnt   <= '0;
                        diff    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= 1'b0;
`endif
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Result fills from the top so bit 0 lands at diff[0] after WIDTH shifts.
                    diff   <= {w_cell_diff, diff[WIDTH-1:1]};
                    r_brw  <= w_cell_bout;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        bout    <= w_cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= w_cell_bout ^ r_brw;
`endif
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks under SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin_init;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin_init (bin_init),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, perturb operands mid-shift, and measure done latency and busy length.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          output int done_cyc, output int busy_cnt, output int done_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        a = ia;
        b = ib;
        bin_init = ibin;
        start = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 2) begin
                a = ~ia;
                b = ~ib;
                bin_init = ~ibin;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
    endtask

    int dc;
    int bc;
    int pc;
    int first_done;
    int second_done;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        bin_init = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_diff", 32'(diff), 32'h0);
        check("reset_bout", 32'(bout), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(ovf), 32'h0);
`endif
        rst = 1'b0;

        run_op(8'h35, 8'h12, 1'b0, dc, bc, pc);
        check("op1_latency", 32'(dc), 32'd9);
        check("op1_busy_cycles", 32'(bc), 32'd9);
        check("op1_done_pulses", 32'(pc), 32'd1);
        check("op1_diff", 32'(diff), 32'h23);
        check("op1_bout", 32'(bout), 32'h0);

        run_op(8'h12, 8'h35, 1'b0, dc, bc, pc);
        check("op2_diff", 32'(diff), 32'hDD);
        check("op2_bout", 32'(bout), 32'h1);

        run_op(8'h00, 8'h00, 1'b1, dc, bc, pc);
        check("op3_diff", 32'(diff), 32'hFF);
        check("op3_bout", 32'(bout), 32'h1);

        run_op(8'hA5, 8'h5A, 1'b1, dc, bc, pc);
        check("op4_diff", 32'(diff), 32'h4A);
        check("op4_bout", 32'(bout), 32'h0);

        run_op(8'hFF, 8'hFF, 1'b1, dc, bc, pc);
        check("op5_diff", 32'(diff), 32'hFF);
        check("op5_bout", 32'(bout), 32'h1);

        // Result must hold while idle inputs wander.
        a = 8'h77;
        b = 8'h11;
        repeat (3) @(negedge clk);
        check("hold_diff", 32'(diff), 32'hFF);
        check("hold_bout", 32'(bout), 32'h1);

        // Start during SHIFT is ignored.
        pc = 0;
        @(negedge clk);
        a = 8'h35;
        b = 8'h12;
        bin_init = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 3) begin
                a = 8'hFF;
                b = 8'h01;
                start = 1'b1;
            end
            if (done) pc++;
        end
        check("busy_start_pulses", 32'(pc), 32'd1);
        check("busy_start_diff", 32'(diff), 32'h23);

        // Reset mid-operation.
        pc = 0;
        @(negedge clk);
        a = 8'h35;
        b = 8'h12;
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) pc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_diff", 32'(diff), 32'h0);
        check("midrst_bout", 32'(bout), 32'h0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (done) pc++;
        end
        check("midrst_no_done", 32'(pc), 32'd0);
        run_op(8'h10, 8'h01, 1'b0, dc, bc, pc);
        check("post_rst_diff", 32'(diff), 32'h0F);
        check("post_rst_bout", 32'(bout), 32'h0);
        check("post_rst_latency", 32'(dc), 32'd9);

        // Start held high: back-to-back acceptance every WIDTH+2 cycles.
        first_done = 0;
        second_done = 0;
        @(negedge clk);
        a = 8'h05;
        b = 8'h03;
        bin_init = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (first_done == 0) first_done = cyc;
                else if (second_done == 0) second_done = cyc;
            end
        end
        start = 1'b0;
        check("b2b_first_done", 32'(first_done), 32'd9);
        check("b2b_spacing", 32'(second_done - first_done), 32'd10);
        repeat (12) @(negedge clk);
        check("b2b_diff", 32'(diff), 32'h02);

`ifdef SERIAL_SUB_OVF_EN
        run_op(8'h80, 8'h01, 1'b0, dc, bc, pc);
        check("ovf1_diff", 32'(diff), 32'h7F);
        check("ovf1_bout", 32'(bout), 32'h0);
        check("ovf1_ovf", 32'(ovf), 32'h1);
        run_op(8'h05, 8'h03, 1'b0, dc, bc, pc);
        check("ovf2_diff", 32'(diff), 32'h02);
        check("ovf2_ovf", 32'(ovf), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
